// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle controller: state encodings, opcodes
// and the ALU function codes the controller drives for PC/SP stepping.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_F0    = 5'd0,
        ST_F1    = 5'd1,
        ST_F2    = 5'd2,
        ST_DEC   = 5'd3,
        ST_ALU   = 5'd4,
        ST_LDA   = 5'd5,
        ST_LDM   = 5'd6,
        ST_LDW   = 5'd7,
        ST_STA   = 5'd8,
        ST_STM   = 5'd9,
        ST_BR    = 5'd10,
        ST_PUSH0 = 5'd11,
        ST_PUSH1 = 5'd12,
        ST_POP0  = 5'd13,
        ST_POP1  = 5'd14,
        ST_CALL  = 5'd15,
        ST_RET   = 5'd16,
        ST_HALT  = 5'd31
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'd0;
    localparam logic [3:0] OP_LDA  = 4'd1;
    localparam logic [3:0] OP_STA  = 4'd2;
    localparam logic [3:0] OP_BRZ  = 4'd3;
    localparam logic [3:0] OP_BRNZ = 4'd4;
    localparam logic [3:0] OP_BR   = 4'd5;
    localparam logic [3:0] OP_PUSH = 4'd6;
    localparam logic [3:0] OP_POP  = 4'd7;
    localparam logic [3:0] OP_CALL = 4'd8;
    localparam logic [3:0] OP_RET  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Sign-extended to the ALU select width: increment is all-ones, decrement ...110.
    localparam logic [2:0] FN_INC = 3'b111;
    localparam logic [2:0] FN_DEC = 3'b110;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode for the multicycle controller. Only the memory-wait
// load strobes and the POP/RET completion actions look at mem_ready.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int IR_W  = 16,
    parameter int OPC_W = 4,
    parameter int FN_W  = 3
) (
    input  logic [4:0]      state,
    input  logic [IR_W-1:0] IR,
    input  logic            z,
    input  logic            mem_ready,
    output logic [FN_W-1:0] fnSel,
    output logic            ldMAR,
    output logic            ldIR,
    output logic            ldPC,
    output logic            ldSP,
    output logic            ldMDR,
    output logic            ldReg,
    output logic            ldRegBank,
    output logic            TReg,
    output logic            TRegBank,
    output logic            TSP,
    output logic            TMAR,
    output logic            TPC,
    output logic            TMDR,
    output logic            TLabel,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            halted
);

    state_t           st;
    logic [OPC_W-1:0] opc;
    logic             br_taken;
    logic             ir_unused;

    assign st        = state_t'(state);
    assign opc       = IR[IR_W-1 -: OPC_W];
    assign ir_unused = ^IR;
    assign br_taken  = (opc == OPC_W'(OP_BR))
                    || ((opc == OPC_W'(OP_BRZ))  &&  z)
                    || ((opc == OPC_W'(OP_BRNZ)) && !z);

    always_comb begin
        fnSel     = '0;
        ldMAR     = 1'b0;
        ldIR      = 1'b0;
        ldPC      = 1'b0;
        ldSP      = 1'b0;
        ldMDR     = 1'b0;
        ldReg     = 1'b0;
        ldRegBank = 1'b0;
        TReg      = 1'b0;
        TRegBank  = 1'b0;
        TSP       = 1'b0;
        TMAR      = 1'b0;
        TPC       = 1'b0;
        TMDR      = 1'b0;
        TLabel    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        halted    = 1'b0;
        case (st)
            ST_F0: begin
                TPC   = 1'b1;
                ldMAR = 1'b1;
            end
            ST_F1: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ldIR    = mem_ready;
            end
            ST_F2: begin
                TPC   = 1'b1;
                ldPC  = 1'b1;
                fnSel = FN_W'($signed(FN_INC));
            end
            ST_ALU: begin
                fnSel     = IR[FN_W-1:0];
                TRegBank  = 1'b1;
                ldReg     = 1'b1;
                ldRegBank = 1'b1;
            end
            ST_LDA, ST_POP0: begin
                TReg  = (st == ST_LDA);
                TSP   = (st == ST_POP0);
                ldMAR = 1'b1;
            end
            ST_LDM: begin
                MemRead = 1'b1;
                ldMDR   = mem_ready;
            end
            ST_LDW: begin
                TMDR      = 1'b1;
                ldRegBank = 1'b1;
            end
            ST_STA: begin
                TReg  = 1'b1;
                ldMAR = 1'b1;
                ldMDR = 1'b1;
            end
            ST_STM: MemWrite = 1'b1;
            ST_BR: begin
                TLabel = br_taken;
                ldPC   = br_taken;
            end
            ST_PUSH0: begin
                TSP   = 1'b1;
                ldMAR = 1'b1;
                ldSP  = 1'b1;
                fnSel = FN_W'($signed(FN_DEC));
            end
            // CALL pushes the return PC through the same two push cycles.
            ST_PUSH1: begin
                TPC      = (opc == OPC_W'(OP_CALL));
                TRegBank = (opc != OPC_W'(OP_CALL));
                ldMDR    = mem_ready;
                MemWrite = 1'b1;
            end
            // RET only captures the popped word here; RET moves it into PC.
            ST_POP1: begin
                MemRead = 1'b1;
                ldMDR   = mem_ready;
                if (mem_ready) begin
                    ldSP      = 1'b1;
                    fnSel     = FN_W'($signed(FN_INC));
                    TMDR      = (opc != OPC_W'(OP_RET));
                    ldRegBank = (opc != OPC_W'(OP_RET));
                end
            end
            ST_CALL: begin
                TLabel = 1'b1;
                ldPC   = 1'b1;
            end
            ST_RET: begin
                TMDR = 1'b1;
                ldPC = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU controller: state register, next-state logic and sticky
// illegal-opcode flag. Define MEM_WAIT_EN to stall memory states on mem_ready.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int IR_W  = 16,
    parameter int OPC_W = 4,
    parameter int FN_W  = 3
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IR_W-1:0] IR,
    input  logic            z,
    input  logic            mem_ready,
    output logic [FN_W-1:0] fnSel,
    output logic            ldMAR,
    output logic            ldIR,
    output logic            ldPC,
    output logic            ldSP,
    output logic            ldMDR,
    output logic            ldReg,
    output logic            ldRegBank,
    output logic            TReg,
    output logic            TRegBank,
    output logic            TSP,
    output logic            TMAR,
    output logic            TPC,
    output logic            TMDR,
    output logic            TLabel,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [4:0]      state,
    output logic            halted,
    output logic            illegal
);

    state_t           st_q;
    state_t           st_d;
    logic [OPC_W-1:0] opc;
    logic             mem_ok;
    logic             ill_op;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic mem_unused;
    assign mem_ok     = 1'b1;
    assign mem_unused = mem_ready;
`endif

    assign opc   = IR[IR_W-1 -: OPC_W];
    assign state = st_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) st_q <= ST_F0;
        else        st_q <= st_d;
    end

    always_comb begin
        st_d   = st_q;
        ill_op = 1'b0;
        case (st_q)
            ST_F0:    st_d = ST_F1;
            ST_F1:    st_d = mem_ok ? ST_F2 : ST_F1;
            ST_F2:    st_d = ST_DEC;
            ST_DEC: begin
                case (opc)
                    OPC_W'(OP_ALU):  st_d = ST_ALU;
                    OPC_W'(OP_LDA):  st_d = ST_LDA;
                    OPC_W'(OP_STA):  st_d = ST_STA;
                    OPC_W'(OP_BRZ),
                    OPC_W'(OP_BRNZ),
                    OPC_W'(OP_BR):   st_d = ST_BR;
                    OPC_W'(OP_PUSH),
                    OPC_W'(OP_CALL): st_d = ST_PUSH0;
                    OPC_W'(OP_POP),
                    OPC_W'(OP_RET):  st_d = ST_POP0;
                    OPC_W'(OP_HALT): st_d = ST_HALT;
                    default: begin
                        st_d   = ST_HALT;
                        ill_op = 1'b1;
                    end
                endcase
            end
            ST_ALU:   st_d = ST_F0;
            ST_LDA:   st_d = ST_LDM;
            ST_LDM:   st_d = mem_ok ? ST_LDW : ST_LDM;
            ST_LDW:   st_d = ST_F0;
            ST_STA:   st_d = ST_STM;
            ST_STM:   st_d = mem_ok ? ST_F0 : ST_STM;
            ST_BR:    st_d = ST_F0;
            ST_PUSH0: st_d = ST_PUSH1;
            ST_PUSH1: begin
                if (mem_ok) st_d = (opc == OPC_W'(OP_CALL)) ? ST_CALL : ST_F0;
            end
            ST_POP0:  st_d = ST_POP1;
            ST_POP1: begin
                if (mem_ok) st_d = (opc == OPC_W'(OP_RET)) ? ST_RET : ST_F0;
            end
            ST_CALL:  st_d = ST_F0;
            ST_RET:   st_d = ST_F0;
            ST_HALT:  st_d = ST_HALT;
            default:  st_d = ST_F0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)      illegal <= 1'b0;
        else if (ill_op) illegal <= 1'b1;
    end

    mc_ctrl_decode #(
        .IR_W  (IR_W),
        .OPC_W (OPC_W),
        .FN_W  (FN_W)
    ) u_decode (
        .state     (st_q),
        .IR        (IR),
        .z         (z),
        .mem_ready (mem_ok),
        .fnSel     (fnSel),
        .ldMAR     (ldMAR),
        .ldIR      (ldIR),
        .ldPC      (ldPC),
        .ldSP      (ldSP),
        .ldMDR     (ldMDR),
        .ldReg     (ldReg),
        .ldRegBank (ldRegBank),
        .TReg      (TReg),
        .TRegBank  (TRegBank),
        .TSP       (TSP),
        .TMAR      (TMAR),
        .TPC       (TPC),
        .TMDR      (TMDR),
        .TLabel    (TLabel),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .halted    (halted)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its
// expected per-cycle state walk and control outputs, then checked cycle by cycle.
module tb_multicycle_controller;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int S_F0 = 0, S_F1 = 1, S_F2 = 2, S_DEC = 3, S_ALU = 4;
    localparam int S_LDA = 5, S_LDM = 6, S_LDW = 7, S_STA = 8, S_STM = 9;
    localparam int S_BR = 10, S_PUSH0 = 11, S_PUSH1 = 12, S_POP0 = 13;
    localparam int S_POP1 = 14, S_CALL = 15, S_RET = 16, S_HALT = 31;

    typedef struct packed {
        logic [2:0] fn;
        logic ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank;
        logic TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel;
        logic MemRead, MemWrite, IRWrite, halted;
    } ctl_t;

    typedef struct {
        int st;
        bit mr;
        bit last;
    } step_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] IR;
    logic        z;
    logic        mem_ready;
    logic [2:0]  fnSel;
    logic ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank;
    logic TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel;
    logic MemRead, MemWrite, IRWrite, halted, illegal;
    logic [4:0]  state;
    ctl_t        act;

    int n_cmp = 0;
    int n_bad = 0;
    int force_w = -1;
    step_t q[$];

    always #5 Clk = ~Clk;

    multicycle_controller dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .z(z), .mem_ready(mem_ready),
        .fnSel(fnSel), .ldMAR(ldMAR), .ldIR(ldIR), .ldPC(ldPC), .ldSP(ldSP),
        .ldMDR(ldMDR), .ldReg(ldReg), .ldRegBank(ldRegBank), .TReg(TReg),
        .TRegBank(TRegBank), .TSP(TSP), .TMAR(TMAR), .TPC(TPC), .TMDR(TMDR),
        .TLabel(TLabel), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .state(state), .halted(halted), .illegal(illegal)
    );

    assign act = {fnSel, ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank,
                  TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel,
                  MemRead, MemWrite, IRWrite, halted};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word for one cycle, written straight from the state descriptions.
    function automatic ctl_t exp_ctl(int st, int opc, bit zz, int fn, bit last);
        ctl_t c = '0;
        bit   tk;
        case (st)
            S_F0:    begin c.TPC = 1; c.ldMAR = 1; end
            S_F1:    begin c.MemRead = 1; c.IRWrite = 1; c.ldIR = last; end
            S_F2:    begin c.TPC = 1; c.ldPC = 1; c.fn = 3'b111; end
            S_ALU:   begin c.fn = 3'(fn); c.TRegBank = 1; c.ldReg = 1; c.ldRegBank = 1; end
            S_LDA:   begin c.TReg = 1; c.ldMAR = 1; end
            S_LDM:   begin c.MemRead = 1; c.ldMDR = last; end
            S_LDW:   begin c.TMDR = 1; c.ldRegBank = 1; end
            S_STA:   begin c.TReg = 1; c.ldMAR = 1; c.ldMDR = 1; end
            S_STM:   c.MemWrite = 1;
            S_BR: begin
                tk = (opc == 5) || (opc == 3 && zz) || (opc == 4 && !zz);
                c.TLabel = tk;
                c.ldPC = tk;
            end
            S_PUSH0: begin c.TSP = 1; c.ldMAR = 1; c.ldSP = 1; c.fn = 3'b110; end
            S_PUSH1: begin
                c.TPC = (opc == 8);
                c.TRegBank = (opc != 8);
                c.ldMDR = last;
                c.MemWrite = 1;
            end
            S_POP0:  begin c.TSP = 1; c.ldMAR = 1; end
            S_POP1: begin
                c.MemRead = 1;
                c.ldMDR = last;
                if (last) begin
                    c.ldSP = 1;
                    c.fn = 3'b111;
                    c.TMDR = (opc != 9);
                    c.ldRegBank = (opc != 9);
                end
            end
            S_CALL:  begin c.TLabel = 1; c.ldPC = 1; end
            S_RET:   begin c.TMDR = 1; c.ldPC = 1; end
            S_HALT:  c.halted = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic void push_st(int st);
        q.push_back('{st, bit'($urandom_range(0, 1)), 1'b0});
    endfunction

    // A memory state: some not-ready cycles (only when stalling is built in), then one completing cycle.
    function automatic void push_mem(int st);
        int w;
        w = !WAIT_EN ? 0 : (force_w >= 0 ? force_w : int'($urandom_range(0, 3)));
        for (int i = 0; i < w; i++) q.push_back('{st, 1'b0, 1'b0});
        q.push_back('{st, WAIT_EN ? 1'b1 : bit'($urandom_range(0, 1)), 1'b1});
    endfunction

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        check_val("rst_state", 32'(state), 32'(S_F0));
        check_val("rst_illegal", 32'(illegal), 0);
        check_val("rst_ctl", 32'(act), 32'(exp_ctl(S_F0, 0, 0, 0, 0)));
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input bit zz, input int abort_st);
        int opc = int'(ir[15:12]);
        int fn  = int'(ir[2:0]);
        q.delete();
        push_st(S_F0);
        push_mem(S_F1);
        push_st(S_F2);
        push_st(S_DEC);
        case (opc)
            0:       push_st(S_ALU);
            1:       begin push_st(S_LDA); push_mem(S_LDM); push_st(S_LDW); end
            2:       begin push_st(S_STA); push_mem(S_STM); end
            3, 4, 5: push_st(S_BR);
            6:       begin push_st(S_PUSH0); push_mem(S_PUSH1); end
            7:       begin push_st(S_POP0); push_mem(S_POP1); end
            8:       begin push_st(S_PUSH0); push_mem(S_PUSH1); push_st(S_CALL); end
            9:       begin push_st(S_POP0); push_mem(S_POP1); push_st(S_RET); end
            default: for (int i = 0; i < 21; i++) push_st(S_HALT);
        endcase
        IR = ir;
        z  = zz;
        foreach (q[i]) begin
            mem_ready = q[i].mr;
            #1;
            check_val($sformatf("state[%0h#%0d]", ir, i), 32'(state), 32'(q[i].st));
            check_val($sformatf("ctl[%0h#%0d]", ir, i), 32'(act),
                      32'(exp_ctl(q[i].st, opc, zz, fn, q[i].last)));
            check_val($sformatf("illegal[%0h#%0d]", ir, i), 32'(illegal),
                      32'(q[i].st == S_HALT && opc != 15));
            check_val("rd_wr_excl", 32'(MemRead & MemWrite), 0);
            if (q[i].st == abort_st) begin
                Reset = 1'b0;
                #1;
                check_val("abort_memwrite", 32'(MemWrite), 0);
                check_val("abort_state", 32'(state), 32'(S_F0));
                check_val("abort_ctl", 32'(act), 32'(exp_ctl(S_F0, 0, 0, 0, 0)));
                @(posedge Clk);
                #1;
                Reset = 1'b1;
                return;
            end
            @(posedge Clk);
            #1;
        end
        if (q[q.size()-1].st == S_HALT) do_reset();
    endtask

    initial begin
        logic [15:0] ir;
        int          opc;
        Reset = 1'b0;
        IR = 16'h0000;
        z = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_val("init_state", 32'(state), 32'(S_F0));
        check_val("init_halted", 32'(halted), 0);
        do_reset();

        run_instr(16'h0000, 1'b0, -1);
        force_w = 3;
        run_instr(16'h1000, 1'b0, -1);
        force_w = -1;
        run_instr(16'h3000, 1'b1, -1);
        run_instr(16'h3000, 1'b0, -1);
        run_instr(16'h4000, 1'b0, -1);
        run_instr(16'h5000, 1'b0, -1);
        force_w = 0;
        run_instr(16'h2000, 1'b0, -1);
        force_w = 2;
        run_instr(16'h6000, 1'b1, S_PUSH1);
        force_w = -1;
        run_instr(16'h8123, 1'b0, -1);
        run_instr(16'h9000, 1'b0, -1);
        run_instr(16'hA000, 1'b0, -1);
        run_instr(16'hF000, 1'b0, -1);

        for (int n = 0; n < 80; n++) begin
            opc = int'($urandom_range(0, 15));
            if (opc >= 10 && $urandom_range(0, 3) != 0) opc = int'($urandom_range(0, 9));
            ir = {4'(opc), 12'($urandom)};
            run_instr(ir, bit'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
